traffic_ctrl_param: RTL
=======================

// Module: traffic_ctrl_param
// PURPOSE
//  Parametrised successor of the intersection controller: main/side street lights plus
//  pedestrian WALK phase. Interval lengths are held in reprogrammable registers.
//  The block has an integrated seconds prescaler and interval timer, so no external
//  'expired' input is needed.
//  It sits between the board I/O (sensor, walk button, programming switches) and the lamp drivers.
//  New over the previous generation: generic timer width, clock-to-second divider,
//  a dedicated walk interval (selector 11), zero-value clamping, and side-green extension.
// PARAMETERS
//  TIME_W    4   width of time_value and of each interval register (seconds)
//  TICK_DIV  50  clk cycles per 1-second tick; must be >= 1
//  DEF_BASE  6   reset value of t_base
//  DEF_EXT   3   reset value of t_ext
//  DEF_YEL   2   reset value of t_yel
//  DEF_WALK  3   reset value of t_walk
// PORTS
//  clk                  in   1       single clock, rising edge
//  reset                in   1       synchronous, active-high
//  sensor               in   1       side-street traffic present
//  walk_request         in   1       pedestrian button, level, sampled each cycle
//  reprogram            in   1       load time_value into the selected interval register
//  time_param_selector  in   2       00 t_base, 01 t_ext, 10 t_yel, 11 t_walk
//  time_value           in   TIME_W  new interval, in seconds
//  Rm,Ym,Gm             out  1       main-street red/yellow/green
//  Rs,Ys,Gs             out  1       side-street red/yellow/green
//  W                    out  1       walk lamp
//  expired              out  1       debug: 1-cycle pulse on the last cycle of the current interval
// BEHAVIOUR
//  - Lamp outputs are a Moore decode of the registered state. Exactly one main lamp and
//    exactly one side lamp are high in every state.
//  - Reset: params <= DEF_*, walk_latch <= 0, state <= GM_BASE, timer loaded with t_base.
//    Outputs after the reset edge: Gm=Rs=1, all others 0, expired=0.
//    reset has priority over every other input.
//  - Timer: on each state entry (or restart) it loads N = interval of the new state and clears
//    the prescaler. expired is high on cycle N*TICK_DIV after the load, and the state changes
//    on the following edge. Every state therefore lasts exactly N*TICK_DIV cycles.
//  - States, their lamps, dwell interval and exit condition:
//     GM_BASE (Gm,Rs)    t_base  -> GM_2; sensor sampled on the expired cycle picks the GM_2 interval
//     GM_2    (Gm,Rs)    t_ext if the sampled sensor was 1, else t_base -> MY
//     MY      (Ym,Rs)    t_yel   -> WALK if (walk_latch | walk_request), else SG
//     WALK    (Rm,Rs,W)  t_walk  -> SG; walk_latch cleared on entry
//     SG      (Rm,Gs)    t_base  -> SG_EXT if sensor=1 on the expired cycle, else SY
//     SG_EXT  (Rm,Gs)    t_ext   -> SY (at most one extension per cycle of the sequence)
//     SY      (Rm,Ys)    t_yel   -> GM_BASE
//  - walk_latch is set by walk_request in any state.
//    A request arriving during WALK (after entry) is held for the next sequence.
//    A request on the MY expired cycle is honoured in that same transition.
//  - Reprogram (reset=0, reprogram=1): param[selector] <= (time_value==0 ? 1 : time_value).
//    The same cycle also sets state <= GM_BASE, reloads the timer with the new t_base value,
//    and clears walk_latch. If reprogram is held, the FSM stays in GM_BASE and the timer
//    reloads every cycle. Counting starts on the first cycle after reprogram falls.
//  - Widths: tick counter is $clog2(TICK_DIV) bits; second counter is TIME_W bits.
//    There is no overflow because N <= 2^TIME_W-1.
//  - Unused or illegal state codes recover to GM_BASE on the next edge.
// STRUCTURE
//  - Package traffic_pkg holds the state enum (7 codes), the selector constants
//    SEL_BASE/EXT/YEL/WALK, and the lamp-vector constants for each state.
//  - One sub-module, traffic_interval_timer (TIME_W, TICK_DIV): ports load, n, expired;
//    it contains the prescaler and the down-counter.
//  - Top level holds the parameter registers, walk_latch, the next-state logic and the lamp decode.
// TESTING  (TICK_DIV=1, defaults)
//  1 reset, sensor=0, no walk: Gm 12 cycles, Ym 2, Gs 6, Ys 2, then Gm again; W never high.
//  2 sensor=1 throughout: Gm 9 cycles (6+3), Ym 2, Gs 9 (6+3), Ys 2.
//  3 1-cycle walk_request during GM_BASE: after Ym, 3 cycles of Rm=Rs=W=1, then Gs.
//    A second request during WALK gives a WALK in the next sequence as well.
//  4 reprogram sel=00 val=2 during SG: next cycle Gm=1, then Gm lasts 4 cycles;
//    a later sel=10 val=0 stores 1, so Ym lasts 1 cycle.
//  5 reset during WALK with walk_latch set: next cycle Gm=Rs=1, W=0; defaults are restored
//    (Gm 12 cycles) and no WALK follows the next Ym.
//  6 TICK_DIV=4: GM_BASE lasts 24 cycles; expired pulses exactly once per state; reset and
//    reprogram asserted together: reset wins and the params equal their defaults.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the parametrised traffic controller.
// Lamp vectors are ordered {Rm, Ym, Gm, Rs, Ys, Gs, W}.
package traffic_pkg;

    typedef enum logic [2:0] {
        GM_BASE = 3'd0,
        GM_2    = 3'd1,
        MY      = 3'd2,
        WALK    = 3'd3,
        SG      = 3'd4,
        SG_EXT  = 3'd5,
        SY      = 3'd6
    } state_t;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_WALK = 2'b11;

    localparam logic [6:0] LAMP_GM   = 7'b0011000;
    localparam logic [6:0] LAMP_MY   = 7'b0101000;
    localparam logic [6:0] LAMP_WALK = 7'b1001001;
    localparam logic [6:0] LAMP_SG   = 7'b1000010;
    localparam logic [6:0] LAMP_SY   = 7'b1000100;

endpackage

// File: rtl/traffic_interval_timer.sv
// Seconds prescaler plus down-counter; expired marks the last cycle
// of an N-second interval counted from the most recent load.
module traffic_interval_timer #(
    parameter int TIME_W   = 4,
    parameter int TICK_DIV = 50
) (
    input  logic              clk,
    input  logic              load,
    input  logic [TIME_W-1:0] n,
    output logic              expired
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]     tick_q, tick_d;
    logic [TIME_W-1:0] sec_q, sec_d;
    logic              tick_wrap;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign expired   = tick_wrap && (sec_q == TIME_W'(1));

    // Load restarts the interval; otherwise prescale and count seconds down
    always_comb begin
        tick_d = tick_q;
        sec_d  = sec_q;
        if (load) begin
            tick_d = '0;
            sec_d  = n;
        end else if (tick_wrap) begin
            tick_d = '0;
            sec_d  = sec_q - TIME_W'(1);
        end else begin
            tick_d = tick_q + CW'(1);
        end
    end

    // Counter registers; the owner always loads on reset and on expiry
    always_ff @(posedge clk) begin
        tick_q <= tick_d;
        sec_q  <= sec_d;
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Intersection controller with programmable intervals, walk phase
// and one side-green extension per sequence.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int TIME_W   = 4,
    parameter int TICK_DIV = 50,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2,
    parameter int DEF_WALK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sensor,
    input  logic              walk_request,
    input  logic              reprogram,
    input  logic [1:0]        time_param_selector,
    input  logic [TIME_W-1:0] time_value,
    output logic              Rm,
    output logic              Ym,
    output logic              Gm,
    output logic              Rs,
    output logic              Ys,
    output logic              Gs,
    output logic              W,
    output logic              expired
);

    state_t            state_q, state_d;
    logic              walk_q, walk_d;
    logic [TIME_W-1:0] t_base_q, t_base_d;
    logic [TIME_W-1:0] t_ext_q, t_ext_d;
    logic [TIME_W-1:0] t_yel_q, t_yel_d;
    logic [TIME_W-1:0] t_walk_q, t_walk_d;
    logic [TIME_W-1:0] val_c;
    logic [TIME_W-1:0] tmr_n;
    logic              tmr_load;
    logic              tmr_exp;
    logic              go_walk;
    logic [6:0]        lamps;

    assign val_c   = (time_value == '0) ? TIME_W'(1) : time_value;
    assign go_walk = walk_q | walk_request;
    assign expired = tmr_exp;

    traffic_interval_timer #(
        .TIME_W  (TIME_W),
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk    (clk),
        .load   (tmr_load),
        .n      (tmr_n),
        .expired(tmr_exp)
    );

    // Reprogramming writes one clamped interval register
    always_comb begin
        t_base_d = t_base_q;
        t_ext_d  = t_ext_q;
        t_yel_d  = t_yel_q;
        t_walk_d = t_walk_q;
        if (reprogram) begin
            case (time_param_selector)
                SEL_BASE: t_base_d = val_c;
                SEL_EXT:  t_ext_d  = val_c;
                SEL_YEL:  t_yel_d  = val_c;
                SEL_WALK: t_walk_d = val_c;
                default:  t_base_d = val_c;
            endcase
        end
    end

    // Interval registers, restored to defaults by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            t_base_q <= TIME_W'(DEF_BASE);
            t_ext_q  <= TIME_W'(DEF_EXT);
            t_yel_q  <= TIME_W'(DEF_YEL);
            t_walk_q <= TIME_W'(DEF_WALK);
        end else begin
            t_base_q <= t_base_d;
            t_ext_q  <= t_ext_d;
            t_yel_q  <= t_yel_d;
            t_walk_q <= t_walk_d;
        end
    end

    // State and walk latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GM_BASE;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end
    end

    // Next state, walk latch and timer reload with the entered interval
    always_comb begin
        state_d  = state_q;
        walk_d   = go_walk;
        tmr_load = 1'b0;
        tmr_n    = t_base_q;
        if (reset) begin
            state_d  = GM_BASE;
            walk_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_n    = TIME_W'(DEF_BASE);
        end else if (reprogram) begin
            state_d  = GM_BASE;
            walk_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_n    = t_base_d;
        end else begin
            tmr_load = tmr_exp;
            case (state_q)
                GM_BASE: begin
                    state_d = GM_2;
                    tmr_n   = sensor ? t_ext_q : t_base_q;
                end
                GM_2: begin
                    state_d = MY;
                    tmr_n   = t_yel_q;
                end
                MY: begin
                    if (go_walk) begin
                        state_d = WALK;
                        tmr_n   = t_walk_q;
                        walk_d  = !tmr_exp;
                    end else begin
                        state_d = SG;
                    end
                end
                WALK: state_d = SG;
                SG: begin
                    state_d = sensor ? SG_EXT : SY;
                    tmr_n   = sensor ? t_ext_q : t_yel_q;
                end
                SG_EXT: begin
                    state_d = SY;
                    tmr_n   = t_yel_q;
                end
                SY: state_d = GM_BASE;
                default: begin
                    state_d  = GM_BASE;
                    tmr_load = 1'b1;
                end
            endcase
            if (!tmr_exp && state_d != GM_BASE) begin
                state_d = state_q;
            end
            if (!tmr_exp && state_q == SY) begin
                state_d = SY;
            end
        end
    end

    // Moore lamp decode of the registered state
    always_comb begin
        case (state_q)
            GM_BASE, GM_2: lamps = LAMP_GM;
            MY:            lamps = LAMP_MY;
            WALK:          lamps = LAMP_WALK;
            SG, SG_EXT:    lamps = LAMP_SG;
            SY:            lamps = LAMP_SY;
            default:       lamps = LAMP_GM;
        endcase
    end

    assign {Rm, Ym, Gm, Rs, Ys, Gs, W} = lamps;

endmodule
